// File: rtl/grant_decoder_pkg.sv
// Shared types and constants for the grant decoder (state encoding, timer width).
package grant_decoder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/grant_decoder_2to4_one_hot_decode.sv
// Combinational binary-to-one-hot expander: out[i] is high exactly when code == i.
module grant_decoder_2to4_one_hot_decode #(
  parameter int CODE_W = 2
) (
  input  logic [CODE_W-1:0]      code,
  output logic [(2**CODE_W)-1:0] one_hot
);

  localparam int N_OUT = 2**CODE_W;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_line
      assign one_hot[gi] = (code == CODE_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/grant_decoder_2to4.sv
// Registered one-hot grant driver with ack handshake; optional hold timeout
// enabled by defining GRANT_DECODER_TIMEOUT_EN.
module grant_decoder_2to4
  import grant_decoder_pkg::*;
#(
  parameter int CODE_W  = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [CODE_W-1:0]       in_code,
  output logic                    in_ready,
  output logic [(2**CODE_W)-1:0]  grant,
  output logic                    grant_valid,
  input  logic                    grant_ack,
  output logic                    timeout
);

  localparam int N_OUT = 2**CODE_W;
  localparam logic [TIMER_W-1:0] TIMEOUT_L = TIMER_W'(TIMEOUT);

  state_t             state_reg, state_next;
  logic [N_OUT-1:0]   grant_reg, grant_next;
  logic               grant_valid_reg;
  logic [N_OUT-1:0]   decoded;
  logic               accept;

  grant_decoder_2to4_one_hot_decode #(
    .CODE_W (CODE_W)
  ) u_decode (
    .code    (in_code),
    .one_hot (decoded)
  );

  // In GRANT the ack doubles as ready so a new code can replace the grant with no idle gap.
  assign in_ready = (state_reg == IDLE) || grant_ack;
  assign accept   = in_valid && in_ready;

`ifdef GRANT_DECODER_TIMEOUT_EN
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               timeout_reg, timeout_next;

  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    timer_next   = timer_reg;
    timeout_next = 1'b0;
    if (accept) begin
      state_next = GRANT;
      grant_next = decoded;
      timer_next = '0;
    end else if (state_reg == GRANT) begin
      if (grant_ack) begin
        state_next = IDLE;
        grant_next = '0;
      end else if (timer_reg == TIMEOUT_L) begin
        state_next   = IDLE;
        grant_next   = '0;
        timeout_next = 1'b1;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timer_reg   <= timer_next;
      timeout_reg <= timeout_next;
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_L;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    if (accept) begin
      state_next = GRANT;
      grant_next = decoded;
    end else if (state_reg == GRANT && grant_ack) begin
      state_next = IDLE;
      grant_next = '0;
    end
  end

  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      grant_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_valid_reg <= |grant_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_valid = grant_valid_reg;

endmodule

// File: tb/tb_grant_decoder_2to4.sv
// Directed bench for grant_decoder_2to4 with a transaction-level reference model
// checked every cycle plus literal expectations.
module tb_grant_decoder_2to4;

  localparam int CODE_W = 2;
  localparam int TO     = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic [3:0] grant;
  logic       grant_valid;
  logic       grant_ack;
  logic       timeout;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  // Reference model: whether a grant is outstanding, which line, how long it has been visible.
  bit m_active = 1'b0;
  int m_idx    = 0;
  int m_age    = 0;
  bit m_pulse  = 1'b0;

  logic [3:0] onehot_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  grant_decoder_2to4 #(
    .CODE_W  (CODE_W),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_code     (in_code),
    .in_ready    (in_ready),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_ack   (grant_ack),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_age    = 0;
      m_pulse  = 1'b0;
    end else begin
      bit rdy;
      rdy     = !m_active || grant_ack;
      m_pulse = 1'b0;
      if (in_valid && rdy) begin
        m_active = 1'b1;
        m_idx    = int'(in_code);
        m_age    = 1;
      end else if (m_active && grant_ack) begin
        m_active = 1'b0;
      end else if (m_active) begin
`ifdef GRANT_DECODER_TIMEOUT_EN
        // A grant may stay visible for at most TIMEOUT+1 cycles without ack.
        if (m_age == TO + 1) begin
          m_active = 1'b0;
          m_pulse  = 1'b1;
        end else begin
          m_age++;
        end
`else
        m_age++;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] exp_grant;
      exp_grant = m_active ? (4'b0001 << m_idx) : 4'b0000;
      chk("model_grant", grant, exp_grant);
      chk("model_grant_valid", grant_valid, m_active);
      chk("model_in_ready", in_ready, !m_active || grant_ack);
      chk("model_timeout", timeout, m_pulse);
      chk("model_onehot", ($countones(grant) <= 1), 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_code   = 2'b00;
    grant_ack = 1'b0;
    tick();
    tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    $display("[TB] reset released");
    chk("reset_grant", grant, 4'b0000);
    chk("reset_grant_valid", grant_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_timeout", timeout, 1'b0);

    // Single decode and release.
    in_valid = 1'b1;
    in_code  = 2'b10;
    tick();
    in_valid = 1'b0;
    $display("[TB] accept code=2 -> grant=%b", grant);
    chk("single_grant", grant, 4'b0100);
    chk("single_grant_valid", grant_valid, 1'b1);
    chk("single_in_ready", in_ready, 1'b0);
    grant_ack = 1'b1;
    #1;
    chk("single_ready_on_ack", in_ready, 1'b1);
    tick();
    grant_ack = 1'b0;
    $display("[TB] ack -> grant=%b", grant);
    chk("single_release", grant, 4'b0000);
    chk("single_release_ready", in_ready, 1'b1);

    // Back-to-back: every switch is accept+ack in the same cycle, including a repeat code.
    in_valid = 1'b1;
    in_code  = 2'b00;
    tick();
    chk("b2b_first", grant, 4'b0001);
    begin
      int seq [6] = '{3, 0, 1, 2, 3, 3};
      for (int i = 0; i < 6; i++) begin
        grant_ack = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'(seq[i]);
        tick();
        $display("[TB] b2b code=%0d -> grant=%b", seq[i], grant);
        chk("b2b_grant", grant, onehot_tbl[seq[i]]);
        chk("b2b_valid", grant_valid, 1'b1);
      end
    end
    in_valid  = 1'b0;
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("b2b_release", grant, 4'b0000);

    // Hold: without ack, new codes are refused.
    in_valid = 1'b1;
    in_code  = 2'b01;
    tick();
    chk("hold_start", grant, 4'b0010);
    in_code = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      $display("[TB] hold cycle %0d grant=%b", i, grant);
      chk("hold_grant", grant, 4'b0010);
      chk("hold_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    grant_ack = 1'b1;
    tick();
    chk("hold_release", grant, 4'b0000);

    // Ack while idle is ignored.
    tick();
    grant_ack = 1'b0;
    chk("idle_ack", grant, 4'b0000);

    // Reset mid-grant with a pending accept that must not be latched.
    in_valid = 1'b1;
    in_code  = 2'b10;
    tick();
    chk("rst_pre", grant, 4'b0100);
    in_code   = 2'b11;
    grant_ack = 1'b1;
    rst_n     = 1'b0;
    tick();
    $display("[TB] reset mid-grant -> grant=%b", grant);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_valid", grant_valid, 1'b0);
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    grant_ack = 1'b0;
    tick();
    chk("rst_not_latched", grant, 4'b0000);

`ifdef GRANT_DECODER_TIMEOUT_EN
    // Timeout with TIMEOUT=3: grant visible 4 cycles, then dropped with one pulse.
    in_valid = 1'b1;
    in_code  = 2'b01;
    tick();
    in_valid = 1'b0;
    chk("to_grant", grant, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_held", grant, 4'b0010);
      chk("to_no_pulse", timeout, 1'b0);
    end
    tick();
    $display("[TB] timeout drop grant=%b timeout=%b", grant, timeout);
    chk("to_drop", grant, 4'b0000);
    chk("to_pulse", timeout, 1'b1);
    tick();
    chk("to_pulse_once", timeout, 1'b0);
    // Ack coinciding with timer==TIMEOUT wins.
    in_valid = 1'b1;
    in_code  = 2'b01;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    $display("[TB] ack at limit grant=%b timeout=%b", grant, timeout);
    chk("to_ack_release", grant, 4'b0000);
    chk("to_ack_no_pulse", timeout, 1'b0);
`else
    // Without the timeout feature the grant is held indefinitely.
    in_valid = 1'b1;
    in_code  = 2'b01;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    $display("[TB] long hold grant=%b timeout=%b", grant, timeout);
    chk("nto_held", grant, 4'b0010);
    chk("nto_timeout", timeout, 1'b0);
    grant_ack = 1'b1;
    tick();
    grant_ack = 1'b0;
    chk("nto_release", grant, 4'b0000);
`endif

    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/grant_decoder_2to4.md
Name: grant_decoder_2to4

Overview:
- Receives a registered one-hot grant request from an upstream priority encoder as a valid binary code (CODE_W bits).
- Drives a one-hot grant, holds it until the consumer acknowledges, then returns ready for the next code.
- Sequential counterpart (decode side) of the 4-to-2 priority encoder: the encoder compresses requests, this block expands the winning index back to one line.

Parameters:
- CODE_W, 2, input code width; number of grant lines N_OUT = 2**CODE_W (default 4).
- TIMEOUT, 15, maximum cycles a grant is held without ack; used only with the optional feature. Legal range 1..255.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  in_code is valid this cycle.
- in_code  in  CODE_W  binary index to decode.
- in_ready  out  1  block accepts in_code this cycle.
- grant  out  N_OUT  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  high whenever grant is non-zero.
- grant_ack  in  1  consumer accepts current grant.
- timeout  out  1  one-cycle pulse on forced grant drop (tied 0 when feature off).

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, grant=0, grant_valid=0, timeout=0, timer=0. Reset has priority over every other event, including mid-grant; the grant drops on the first edge with rst_n=0.
- The FSM has two states:
  - IDLE: in_ready=1.
  - GRANT: in_ready=grant_ack, which allows back-to-back transfers.
- Accept: in_valid && in_ready at an edge latches in_code. On the next cycle, grant = 1<<in_code, grant_valid=1, state=GRANT. Latency from accept to grant is 1 cycle.
- In GRANT with grant_ack=1 and no new accept: grant clears to 0 on the next edge, state=IDLE.
- In GRANT with grant_ack=1 and in_valid=1 (simultaneous): the new code is latched, grant switches directly to the new one-hot on the next edge, and state stays GRANT. grant is never all-zero between the two grants. The same code is allowed; grant then stays unchanged but counts as a new grant.
- In GRANT with grant_ack=0: grant holds stable, and in_code/in_valid are ignored (in_ready=0).
- grant_ack in IDLE is ignored.
- grant is always zero or exactly one-hot. grant_valid equals the OR-reduction of grant, and is registered, not combinational.
- in_code X/Z while in_valid=0 has no effect. A code is never sampled without in_valid.

Optional Feature:
- Macro: GRANT_DECODER_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit timer clears on every new grant and increments each GRANT cycle without ack.
  - When the timer reaches TIMEOUT with grant_ack=0, the next edge clears grant, goes to IDLE, and pulses timeout=1 for exactly one cycle.
  - If ack and timer==TIMEOUT coincide, the ack wins and no timeout pulse is produced.
- Without the macro: there is no timer, timeout is constant 0, and a grant holds indefinitely.

Decomposition:
- Package grant_decoder_pkg holds the state enum (IDLE, GRANT) and the TIMER_W=8 constant.
- A one_hot_decode sub-module (purely combinational, CODE_W in, 2**CODE_W out) is natural and reusable. The FSM, code register and timer stay in the top.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> grant=0000, grant_valid=0, in_ready=1, timeout=0.
- Single decode: in_valid=1, in_code=2'b10 for 1 cycle -> next cycle grant=0100, grant_valid=1, in_ready=0; grant_ack=1 one cycle -> following cycle grant=0000, in_ready=1.
- Back-to-back: in GRANT with grant=0001, drive grant_ack=1, in_valid=1, in_code=2'b11 same cycle -> next cycle grant=1000 with no zero gap; sweep codes 00..11 -> 0001, 0010, 0100, 1000.
- Hold/ignore: in GRANT with grant=0010 and grant_ack=0, drive in_valid=1, in_code=2'b00 for 5 cycles -> grant stays 0010, in_ready=0.
- Reset mid-grant: grant=0100 active, rst_n=0 one edge -> grant=0000, state IDLE; a pending in_valid during reset is not latched.
- Timeout (macro on, TIMEOUT=3): grant to code 01, no ack -> grant=0010 held, then dropped to 0000 with a single timeout=1 pulse after the timer reaches 3; ack on that same cycle -> no pulse, normal release.
